// File: rtl/mcp3208_pkg.sv
// Shared types, frame constants and channel-selection helpers for the
// MCP3208 round-robin scanner.
package mcp3208_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PICK  = 3'd1,
      SETUP = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } state_e;

   localparam int FRAME_SCLKS     = 19;  // SCLK rises per conversion frame
   localparam int CMD_BITS        = 5;   // start, SGL/DIFF, D2, D1, D0
   localparam int FIRST_DATA_RISE = 8;   // rise that samples B11
   localparam int RES_BITS        = 12;

   // Next set bit of mask strictly above ptr, wrapping 7 -> 0. When the only
   // set bit is ptr itself the wrap brings the search back round to ptr.
   function automatic logic [2:0] next_chan(input logic [7:0] mask, input logic [2:0] ptr);
      logic [2:0] c;
      logic       found;
      next_chan = ptr;
      found     = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         c = ptr + 3'(i);
         if (!found && mask[c]) begin
            next_chan = c;
            found     = 1'b1;
         end
      end
   endfunction

   // True when no enabled channel sits above ch, i.e. ch closes a scan pass.
   function automatic logic is_last(input logic [7:0] mask, input logic [2:0] ch);
      logic above;
      above = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > int'(ch) && mask[i]) above = 1'b1;
      end
      return !above;
   endfunction

endpackage

// File: rtl/mcp3208_scan_if.sv
// Result bus from the scanner to the register/readout fabric.
// Handshake: result_valid is a one-cycle strobe with no ready/backpressure;
// result_chan, result_data and scan_done are meaningful in the cycle
// result_valid is high and the consumer must take them in that cycle.
// state is the scanner FSM state, exported for observation only.
interface mcp3208_scan_if;
   import mcp3208_pkg::*;

   logic                result_valid;
   logic [2:0]          result_chan;
   logic [RES_BITS-1:0] result_data;
   logic                scan_done;
   state_e              state;

   modport master (output result_valid, result_chan, result_data, scan_done, state);
   modport slave  (input  result_valid, result_chan, result_data, scan_done, state);
endinterface

// File: rtl/mcp3208_frame.sv
// One MCP3208 conversion frame: setup half-period with the start bit on DIN,
// then 19 SCLK periods (high half first). Command bits change on SCLK-falling
// clk edges, DOUT is sampled on SCLK-rising clk edges, rises 8..19 give B11..B0.
module mcp3208_frame
   import mcp3208_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [2:0]          ch_i,
   input  logic                diff_i,
   input  logic                adc_dout_i,
   output logic                setup_done_o,
   output logic                done_o,
   output logic [RES_BITS-1:0] data_o,
   output logic                adc_cs_o,
   output logic                adc_sclk_o,
   output logic                adc_din_o
);

   localparam int         DW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [5:0] LAST_HALF = 6'(2 * FRAME_SCLKS);
   localparam logic [4:0] CAP_FROM  = 5'(FIRST_DATA_RISE - 1);

   // half_q: 0 = setup half, odd = SCLK high half, even (>0) = SCLK low half
   logic                active_q;
   logic [DW-1:0]       div_q;
   logic [5:0]          half_q;
   logic [4:0]          rise_q;
   logic [CMD_BITS-1:0] cmd_q;
   logic [RES_BITS-1:0] sr_q;
   logic                cs_q;
   logic                sclk_q;
   logic                din_q;
   logic                half_end;

   assign half_end     = active_q && (div_q == DW'(DIV - 1));
   assign setup_done_o = half_end && (half_q == 6'd0);
   assign done_o       = half_end && (half_q == LAST_HALF);
   assign data_o       = sr_q;
   assign adc_cs_o     = cs_q;
   assign adc_sclk_o   = sclk_q;
   assign adc_din_o    = din_q;

   // Divider, half-period sequencing, command shift-out and result shift-in.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         div_q    <= '0;
         half_q   <= '0;
         rise_q   <= '0;
         cmd_q    <= '0;
         sr_q     <= '0;
         cs_q     <= 1'b1;
         sclk_q   <= 1'b0;
         din_q    <= 1'b0;
      end else if (start_i) begin
         active_q <= 1'b1;
         div_q    <= '0;
         half_q   <= '0;
         rise_q   <= '0;
         sr_q     <= '0;
         cs_q     <= 1'b0;
         sclk_q   <= 1'b0;
         din_q    <= 1'b1;                        // start bit
         cmd_q    <= {~diff_i, ch_i, 1'b0};       // SGL, D2, D1, D0, then zeros
      end else if (half_end) begin
         div_q <= '0;
         if (half_q == LAST_HALF) begin
            active_q <= 1'b0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            din_q    <= 1'b0;
         end else begin
            half_q <= half_q + 6'd1;
            if (!half_q[0]) begin
               sclk_q <= 1'b1;
               rise_q <= rise_q + 5'd1;
               if (rise_q >= CAP_FROM) sr_q <= {sr_q[RES_BITS-2:0], adc_dout_i};
            end else begin
               sclk_q <= 1'b0;
               din_q  <= cmd_q[CMD_BITS-1];
               cmd_q  <= {cmd_q[CMD_BITS-2:0], 1'b0};
            end
         end
      end else if (active_q) begin
         div_q <= div_q + DW'(1);
      end
   end

endmodule

// File: rtl/mcp3208_scan.sv
// Round-robin MCP3208 scan scheduler: picks the next enabled channel, runs a
// conversion frame and publishes the result with its channel on a strobe.
module mcp3208_scan
   import mcp3208_pkg::*;
#(
   parameter int DIV = 4,
   parameter int GAP = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   input  logic [7:0]     chan_mask,
   input  logic           diff,
   output logic           busy,
   output logic           adc_cs,
   output logic           adc_sclk,
   output logic           adc_din,
   input  logic           adc_dout,
   mcp3208_scan_if.master res
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   state_e              state_q, state_d;
   logic [2:0]          ptr_q;
   logic                last_q;
   logic [GW-1:0]       gap_q;
   logic                valid_q;
   logic                done_q;
   logic [2:0]          chan_q;
   logic [RES_BITS-1:0] data_q;

   logic [2:0]          pick_ch;
   logic                frame_start;
   logic                setup_done;
   logic                frame_done;
   logic [RES_BITS-1:0] frame_data;

   assign pick_ch = next_chan(chan_mask, ptr_q);

   mcp3208_frame #(.DIV(DIV)) u_frame (
      .clk          (clk),
      .rst          (rst),
      .start_i      (frame_start),
      .ch_i         (pick_ch),
      .diff_i       (diff),
      .adc_dout_i   (adc_dout),
      .setup_done_o (setup_done),
      .done_o       (frame_done),
      .data_o       (frame_data),
      .adc_cs_o     (adc_cs),
      .adc_sclk_o   (adc_sclk),
      .adc_din_o    (adc_din)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: frame phases follow the frame engine's timing pulses.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable && (chan_mask != 8'd0)) state_d = PICK;
         PICK:    state_d = (chan_mask != 8'd0) ? SETUP : IDLE;
         SETUP:   if (setup_done) state_d = SHIFT;
         SHIFT:   if (frame_done) state_d = HOLD;
         HOLD:    if (gap_q == GW'(GAP - 1))
                     state_d = (enable && (chan_mask != 8'd0)) ? PICK : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy outside IDLE, frame launch on a PICK with channels left.
   always_comb begin
      busy        = (state_q != IDLE);
      frame_start = (state_q == PICK) && (chan_mask != 8'd0);
   end

   // Pointer, inter-frame gap counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= 3'd7;
         last_q  <= 1'b0;
         gap_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         chan_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         gap_q   <= (state_q == HOLD) ? gap_q + GW'(1) : '0;
         if (frame_start) begin
            ptr_q  <= pick_ch;
            last_q <= is_last(chan_mask, pick_ch);
         end
         if ((state_q == SHIFT) && frame_done) begin
            valid_q <= 1'b1;
            done_q  <= last_q;
            chan_q  <= ptr_q;
            data_q  <= frame_data;
         end
      end
   end

   assign res.result_valid = valid_q;
   assign res.result_chan  = chan_q;
   assign res.result_data  = data_q;
   assign res.scan_done    = done_q;
   assign res.state        = state_q;

endmodule
